// File: rtl/demux_pkg.sv
// Shared definitions for the buffered 1-to-2 stream demultiplexer.
package demux_pkg;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    // Occupancy counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO: dout always shows the head entry.
module sync_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [count_w(DEPTH)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Requests against a full or empty FIFO are dropped here as well as upstream.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage is reset too, so dout reads 0 after reset instead of stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every update based on pre-edge values.
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/demux_1_2_buf.sv
// Buffered 1-to-2 stream demux: in_sel steers each input word into channel A or B.
module demux_1_2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sel,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      a_valid,
    input  logic                      a_ready,
    output logic [WIDTH-1:0]          a_data,
    output logic                      b_valid,
    input  logic                      b_ready,
    output logic [WIDTH-1:0]          b_data,
    output logic [count_w(DEPTH)-1:0] a_count,
    output logic [count_w(DEPTH)-1:0] b_count
);

    logic a_full;
    logic b_full;
    logic a_empty;
    logic b_empty;
    logic push_a;
    logic push_b;

    // Ready follows only the addressed channel, so a full channel never blocks the other.
    assign in_ready = (in_sel == SEL_A) ? !a_full : !b_full;
    assign push_a   = in_valid && in_ready && (in_sel == SEL_A);
    assign push_b   = in_valid && in_ready && (in_sel == SEL_B);

    assign a_valid = !a_empty;
    assign b_valid = !b_empty;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (push_a),
        .pop   (a_valid && a_ready),
        .din   (in_data),
        .dout  (a_data),
        .full  (a_full),
        .empty (a_empty),
        .count (a_count)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (push_b),
        .pop   (b_valid && b_ready),
        .din   (in_data),
        .dout  (b_data),
        .full  (b_full),
        .empty (b_empty),
        .count (b_count)
    );

endmodule

// File: tb/tb_demux_1_2_buf.sv
// Directed-vector bench for demux_1_2_buf with WIDTH=32, DEPTH=2.
module tb_demux_1_2_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel;
    logic [31:0] in_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_data;
    logic [1:0]  a_count;
    logic [1:0]  b_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    demux_1_2_buf #(.WIDTH(32), .DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    typedef struct {
        logic        valid;
        logic        sel;
        logic [31:0] data;
        logic        ar;
        logic        br;
        logic        exp_ready;
        logic        exp_av;
        logic [31:0] exp_ad;
        logic [1:0]  exp_ac;
        logic        exp_bv;
        logic [31:0] exp_bd;
        logic [1:0]  exp_bc;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic s, input logic [31:0] d,
                                input logic ar, input logic br, input logic rdy,
                                input logic av, input logic [31:0] ad, input logic [1:0] ac,
                                input logic bv, input logic [31:0] bd, input logic [1:0] bc);
        vec_t t;
        t.valid = v;  t.sel = s;  t.data = d;  t.ar = ar;  t.br = br;
        t.exp_ready = rdy;
        t.exp_av = av;  t.exp_ad = ad;  t.exp_ac = ac;
        t.exp_bv = bv;  t.exp_bd = bd;  t.exp_bc = bc;
        return t;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [31:0] d, input logic ar, input logic br);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
    endtask

    initial begin
        int sent;
        int rcvd;
        int cyc;
        logic popped;
        logic accepted;

        // valid sel data ar br | ready | av ad ac | bv bd bc  (data checked only when valid)
        // Alternating routing with both consumers ready.
        vecs[0]  = mk(1, 1, 32'h11, 1, 1, 1, 1, 32'h11, 1, 0, 0,      0);
        vecs[1]  = mk(1, 0, 32'h22, 1, 1, 1, 0, 0,      0, 1, 32'h22, 1);
        vecs[2]  = mk(1, 1, 32'h33, 1, 1, 1, 1, 32'h33, 1, 0, 0,      0);
        vecs[3]  = mk(1, 0, 32'h44, 1, 1, 1, 0, 0,      0, 1, 32'h44, 1);
        vecs[4]  = mk(0, 1, 32'h0,  1, 1, 1, 0, 0,      0, 0, 0,      0);
        // B stalled: fills at 2, blocks only B-addressed words.
        vecs[5]  = mk(1, 0, 32'h55, 1, 0, 1, 0, 0,      0, 1, 32'h55, 1);
        vecs[6]  = mk(1, 0, 32'h66, 1, 0, 1, 0, 0,      0, 1, 32'h55, 2);
        vecs[7]  = mk(1, 0, 32'h77, 1, 0, 0, 0, 0,      0, 1, 32'h55, 2);
        vecs[8]  = mk(1, 1, 32'h88, 1, 0, 1, 1, 32'h88, 1, 1, 32'h55, 2);
        vecs[9]  = mk(0, 1, 32'h0,  1, 1, 1, 0, 0,      0, 1, 32'h66, 1);
        vecs[10] = mk(0, 1, 32'h0,  1, 1, 1, 0, 0,      0, 0, 0,      0);
        // A full with a pop pending: no pass-through, word taken the next cycle.
        vecs[11] = mk(1, 1, 32'hA1, 0, 1, 1, 1, 32'hA1, 1, 0, 0,      0);
        vecs[12] = mk(1, 1, 32'hA2, 0, 1, 1, 1, 32'hA1, 2, 0, 0,      0);
        vecs[13] = mk(1, 1, 32'hA3, 1, 1, 0, 1, 32'hA2, 1, 0, 0,      0);
        vecs[14] = mk(1, 1, 32'hA3, 1, 1, 1, 1, 32'hA3, 1, 0, 0,      0);
        vecs[15] = mk(0, 1, 32'h0,  1, 1, 1, 0, 0,      0, 0, 0,      0);
        // Simultaneous push and pop on B at count 1.
        vecs[16] = mk(1, 0, 32'hB1, 1, 0, 1, 0, 0,      0, 1, 32'hB1, 1);
        vecs[17] = mk(1, 0, 32'hB2, 1, 1, 1, 0, 0,      0, 1, 32'hB2, 1);
        vecs[18] = mk(0, 1, 32'h0,  1, 1, 1, 0, 0,      0, 0, 0,      0);

        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0);
        #2;
        check("reset_a_valid", 32'(a_valid), 32'h0);
        check("reset_b_valid", 32'(b_valid), 32'h0);
        check("reset_a_count", 32'(a_count), 32'h0);
        check("reset_b_count", 32'(b_count), 32'h0);
        check("reset_a_data", a_data, 32'h0);
        check("reset_b_data", b_data, 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].ar, vecs[i].br);
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_a_valid", i), 32'(a_valid), 32'(vecs[i].exp_av));
            check($sformatf("v%0d_a_count", i), 32'(a_count), 32'(vecs[i].exp_ac));
            check($sformatf("v%0d_b_valid", i), 32'(b_valid), 32'(vecs[i].exp_bv));
            check($sformatf("v%0d_b_count", i), 32'(b_count), 32'(vecs[i].exp_bc));
            if (vecs[i].exp_av) check($sformatf("v%0d_a_data", i), a_data, vecs[i].exp_ad);
            if (vecs[i].exp_bv) check($sformatf("v%0d_b_data", i), b_data, vecs[i].exp_bd);
        end

        // Wrap-around: 10 words to A with a_ready toggling each cycle.
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 10 && cyc < 200) begin
            @(negedge clk);
            drive(sent < 10, 1'b1, 32'h100 + 32'(sent), cyc[0], 1'b1);
            #1;
            accepted = in_valid && in_ready;
            popped   = a_valid && a_ready;
            if (popped) begin
                check("wrap_data", a_data, 32'h100 + 32'(rcvd));
                rcvd++;
            end
            if (accepted) sent++;
            @(posedge clk);
            cyc++;
        end
        check("wrap_received", 32'(rcvd), 32'd10);
        @(negedge clk);
        drive(0, 1, 32'h0, 1, 1);
        #1;
        check("wrap_drained", 32'(a_valid), 32'h0);

        // Reset mid-stream with A=2, B=1.
        @(negedge clk);
        drive(1, 1, 32'hC1, 0, 0);
        @(negedge clk);
        drive(1, 1, 32'hC2, 0, 0);
        @(negedge clk);
        drive(1, 0, 32'hD1, 0, 0);
        @(negedge clk);
        drive(0, 1, 32'h0, 0, 0);
        #1;
        check("pre_rst_a_count", 32'(a_count), 32'd2);
        check("pre_rst_b_count", 32'(b_count), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_a_valid", 32'(a_valid), 32'h0);
        check("mid_rst_b_valid", 32'(b_valid), 32'h0);
        check("mid_rst_a_count", 32'(a_count), 32'h0);
        check("mid_rst_b_count", 32'(b_count), 32'h0);
        check("mid_rst_a_data", a_data, 32'h0);
        check("mid_rst_b_data", b_data, 32'h0);
        check("mid_rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 32'hE1, 0, 0);
        #1;
        check("post_rst_pre_edge_a_valid", 32'(a_valid), 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_a_valid", 32'(a_valid), 32'h1);
        check("post_rst_a_data", a_data, 32'hE1);
        check("post_rst_a_count", 32'(a_count), 32'h1);
        @(negedge clk);
        drive(0, 1, 32'h0, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_1_2_buf.md
# demux_1_2_buf

Buffered 1-to-2 stream demultiplexer, the routing counterpart of the 2-to-1 select muxes in the datapath: one valid/ready input stream is steered to channel A or channel B, and each channel has its own small first-word-fall-through FIFO. The processor uses it to split the store/write-back stream between data memory (A) and the MMIO/peripheral path (B). A stalled consumer on one channel does not block traffic to the other until that channel's FIFO fills.

## Interface
- WIDTH, 32, data width of input and both outputs
- DEPTH, 2, entries per channel FIFO; power of two, ≥2
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  input word accepted this cycle when in_valid is also high
- in_sel  input  1  1 routes to A, 0 routes to B (same polarity as sel ? a : b)
- in_data  input  WIDTH  input word
- a_valid  output  1  channel A FIFO non-empty
- a_ready  input  1  channel A consumer pops when a_valid is also high
- a_data  output  WIDTH  head of channel A FIFO
- b_valid, b_ready, b_data  same as A, for channel B
- a_count, b_count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Push: a push to channel X occurs when in_valid && in_ready, with X selected by in_sel.
- in_ready is combinational: it equals !full of the channel selected by in_sel. It does not depend on in_valid.
- in_sel and in_data must be held stable while in_valid is high and in_ready is low. Changing in_sel mid-stall is a protocol violation.
- Pop: a pop on X occurs when X_valid && X_ready. X_data always shows mem[rd_ptr] (FWFT).
- Per channel:
  - wr_ptr and rd_ptr wrap modulo DEPTH.
  - Count is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
- Full (count==DEPTH): in_ready is low for that channel, even if a pop happens in the same cycle. There is no pass-through on full.
- Empty (count==0): X_valid is low, and a pop request is ignored.
- Ordering: order is preserved within a channel. There is no ordering relation between the two channels.
- Reset:
  - All pointers and counts go to 0, and a_valid/b_valid go low.
  - Storage is cleared to 0, so a_data and b_data read 0.
  - in_ready is high after reset.
- Reset mid-operation discards all buffered words immediately, asynchronously.

## Timing
- Latency is 1 cycle: a word pushed at edge N is visible on X_valid/X_data after edge N.
- Throughput is one push per cycle, plus one pop per channel per cycle.
- A pop at edge N frees space. in_ready rises combinationally in cycle N+1.
- A full channel only ever blocks input words addressed to it. The other channel continues at full rate.
- All outputs except in_ready are registered or come directly from registers.

## Structure
- Shared package demux_pkg:
  - SEL_A = 1'b1 and SEL_B = 1'b0
  - count width function, clog2-based
- Sub-module sync_fifo (WIDTH, DEPTH): FWFT, with ports push, pop, din, dout, full, empty, count. It is instantiated twice, once per channel.
- The top level holds only the in_sel steering and the ready mux.

## Test plan
- Route 4 words (0x11, 0x22, 0x33, 0x44) alternating in_sel=1,0,1,0 with a_ready=b_ready=1. Required: a_data sees 0x11 then 0x33, b_data sees 0x22 then 0x44. Each appears 1 cycle after acceptance, and counts never exceed 1.
- Set b_ready=0 and push 3 words with in_sel=0. Required: the first 2 are accepted, and b_count=2. in_ready stays low for the third while in_sel=0. Switching to a new in_sel=1 word shows in_ready=1, and that word is accepted to A.
- Channel A full (count 2) with a_ready=1 and a new A word pending in the same cycle. Required: in_ready=0 in that cycle, and in_ready=1 in the next, when the word is accepted. Data order is 1st, 2nd, new.
- Wrap-around: stream 10 words to A with a_ready toggling every cycle. Required: all 10 emerge in order with no loss or duplication.
- Simultaneous push and pop on B at count 1. Required: b_count stays 1, and b_data advances to the newly pushed word after the old head drains.
- Assert rst mid-stream with A=2 and B=1. Required: immediately a_valid=b_valid=0, counts 0, data 0, and in_ready=1. After release, the first push appears 1 cycle later.
